// File: rtl/bbox_pkg.sv
// Shared types and helpers for the bounding-box scanner: FSM states,
// darkness-mode encoding and the row-stride rounding rule.
package bbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_ANY = 1'b0;  // dark if any channel is below threshold
  localparam logic MODE_ALL = 1'b1;  // dark only if every channel is below threshold

  // Rows are padded so each one starts on a 4-byte boundary.
  function automatic int unsigned stride_round(input int unsigned w, input int unsigned c);
    return ((w * c + 3) / 4) * 4;
  endfunction

endpackage

// File: rtl/bbox_scanner_if.sv
// Read-only memory bus between the scanner (master) and image storage (slave).
interface bbox_scanner_if #(
  parameter int DATA_W = 8
);
  logic [31:0]       addr;
  logic              rd_en;
  logic [DATA_W-1:0] rddata;

  modport master (output addr, output rd_en, input rddata);
  modport slave  (input addr, input rd_en, output rddata);
endinterface

// File: rtl/bbox_addr_gen.sv
// Walks the image bottom row first, left to right, channel by channel, and
// produces the byte address plus the (x, y, c) of each read.
module bbox_addr_gen
  import bbox_pkg::*;
#(
  parameter int WIDTH    = 100,
  parameter int HEIGHT   = 100,
  parameter int CHANNELS = 3,
  parameter int COORD_W  = 11,
  parameter int CW       = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_scan,
  input  logic [31:0]        i_base,
  output logic [31:0]        o_addr,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic [CW-1:0]      o_c,
  output logic               o_last
);

  localparam int unsigned STRIDE   = stride_round(WIDTH, CHANNELS);
  localparam logic [31:0] STRIDE_L = 32'(STRIDE);
  localparam logic [31:0] ROW_TOP  = 32'((HEIGHT - 1) * STRIDE);

  logic [31:0]        r_base;
  logic [31:0]        r_row;
  logic [31:0]        r_addr;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [CW-1:0]      r_c;

  logic w_c_end;
  logic w_x_end;

  assign w_c_end = (r_c == CW'(CHANNELS - 1));
  assign w_x_end = (r_x == COORD_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base <= '0;
      r_row  <= '0;
      r_addr <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_c    <= '0;
    end else if (i_load) begin
      r_base <= i_base;
      r_row  <= i_base + ROW_TOP;
      r_addr <= i_base + ROW_TOP;
      r_x    <= '0;
      r_y    <= COORD_W'(HEIGHT - 1);
      r_c    <= '0;
    end else if (i_scan) begin
      if (!w_c_end) begin
        r_c    <= r_c + CW'(1);
        r_addr <= r_addr + 32'd1;
      end else if (!w_x_end) begin
        r_c    <= '0;
        r_x    <= r_x + COORD_W'(1);
        r_addr <= r_addr + 32'd1;
      end else begin
        // Step down one row; the row base absorbs the padding bytes.
        r_c    <= '0;
        r_x    <= '0;
        r_y    <= r_y - COORD_W'(1);
        r_row  <= r_row - STRIDE_L;
        r_addr <= r_row - STRIDE_L;
      end
    end
  end

  assign o_addr = i_scan ? r_addr : r_base;
  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_c    = r_c;
  assign o_last = w_c_end && w_x_end && (r_y == '0);

endmodule

// File: rtl/bbox_scanner.sv
// Scans an image in memory and reports the bounding box of dark pixels.
// Optional BBOX_PIXCOUNT_EN adds a pix_count output counting dark pixels.
module bbox_scanner
  import bbox_pkg::*;
#(
  parameter int WIDTH      = 100,
  parameter int HEIGHT     = 100,
  parameter int CHANNELS   = 3,
  parameter int RD_LATENCY = 1,
  parameter int COORD_W    = 11,
  parameter int DATA_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic [DATA_W-1:0]  threshold,
  input  logic [31:0]        base_addr,
  bbox_scanner_if.master     mem,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [COORD_W-1:0] xMin,
  output logic [COORD_W-1:0] xMax,
  output logic [COORD_W-1:0] yMin,
  output logic [COORD_W-1:0] yMax
`ifdef BBOX_PIXCOUNT_EN
  ,
  output logic [2*COORD_W-1:0] pix_count
`endif
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_t r_state;
  state_t w_next;

  logic              w_accept;
  logic              w_scan;
  logic              r_mode;
  logic [DATA_W-1:0] r_thr;

  logic [31:0]        w_addr;
  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic [CW-1:0]      w_c;
  logic               w_last;

  assign w_scan   = (r_state == ST_SCAN);
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  bbox_addr_gen #(
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .CHANNELS (CHANNELS),
    .COORD_W  (COORD_W),
    .CW       (CW)
  ) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_scan (w_scan),
    .i_base (base_addr),
    .o_addr (w_addr),
    .o_x    (w_x),
    .o_y    (w_y),
    .o_c    (w_c),
    .o_last (w_last)
  );

  assign mem.addr  = w_addr;
  assign mem.rd_en = w_scan;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_ANY;
      r_thr   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mode <= mode;
        r_thr  <= threshold;
      end
    end
  end

  logic r_fin;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start)  w_next = ST_SCAN;
      ST_SCAN:  if (w_last) w_next = ST_DRAIN;
      ST_DRAIN: if (r_fin)  w_next = ST_DONE;
      ST_DONE:  if (start)  w_next = ST_SCAN;
      default:              w_next = ST_IDLE;
    endcase
  end

  assign busy = (r_state == ST_SCAN) || (r_state == ST_DRAIN);
  assign done = (r_state == ST_DONE);

  // Read-tag pipeline: stage RD_LATENCY-1 lines up with mem.rddata.
  logic               r_pv [RD_LATENCY];
  logic [COORD_W-1:0] r_px [RD_LATENCY];
  logic [COORD_W-1:0] r_py [RD_LATENCY];
  logic [CW-1:0]      r_pc [RD_LATENCY];
  logic               r_pl [RD_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) r_pv[i] <= 1'b0;
    end else begin
      r_pv[0] <= w_scan;
      for (int i = 1; i < RD_LATENCY; i++) r_pv[i] <= r_pv[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_px[0] <= w_x;
    r_py[0] <= w_y;
    r_pc[0] <= w_c;
    r_pl[0] <= w_last;
    for (int i = 1; i < RD_LATENCY; i++) begin
      r_px[i] <= r_px[i-1];
      r_py[i] <= r_py[i-1];
      r_pc[i] <= r_pc[i-1];
      r_pl[i] <= r_pl[i-1];
    end
  end

  logic               w_arr;
  logic [COORD_W-1:0] w_ax;
  logic [COORD_W-1:0] w_ay;
  logic               w_first;
  logic               w_pix;
  logic               w_lo;
  logic               w_any;
  logic               w_all;
  logic               w_dark;
  logic               r_any;
  logic               r_all;

  assign w_arr   = r_pv[RD_LATENCY-1];
  assign w_ax    = r_px[RD_LATENCY-1];
  assign w_ay    = r_py[RD_LATENCY-1];
  assign w_first = (r_pc[RD_LATENCY-1] == '0);
  assign w_pix   = w_arr && (r_pc[RD_LATENCY-1] == CW'(CHANNELS - 1));
  assign w_lo    = (mem.rddata < r_thr);
  assign w_any   = w_first ? w_lo : (r_any | w_lo);
  assign w_all   = w_first ? w_lo : (r_all & w_lo);
  assign w_dark  = (r_mode == MODE_ALL) ? w_all : w_any;

  always_ff @(posedge clk) begin
    if (w_arr) begin
      r_any <= w_any;
      r_all <= w_all;
    end
  end

  logic               r_found;
  logic [COORD_W-1:0] r_xmin;
  logic [COORD_W-1:0] r_xmax;
  logic [COORD_W-1:0] r_ymin;
  logic [COORD_W-1:0] r_ymax;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_found <= 1'b0;
      r_xmin  <= COORD_W'(WIDTH - 1);
      r_ymin  <= COORD_W'(HEIGHT - 1);
      r_xmax  <= '0;
      r_ymax  <= '0;
      r_fin   <= 1'b0;
    end else if (w_accept) begin
      r_found <= 1'b0;
      r_xmin  <= COORD_W'(WIDTH - 1);
      r_ymin  <= COORD_W'(HEIGHT - 1);
      r_xmax  <= '0;
      r_ymax  <= '0;
      r_fin   <= 1'b0;
    end else begin
      if (w_pix && w_dark) begin
        r_found <= 1'b1;
        if (w_ax < r_xmin) r_xmin <= w_ax;
        if (w_ax > r_xmax) r_xmax <= w_ax;
        if (w_ay < r_ymin) r_ymin <= w_ay;
        if (w_ay > r_ymax) r_ymax <= w_ay;
      end
      if (w_arr && r_pl[RD_LATENCY-1]) r_fin <= 1'b1;
    end
  end

  assign found = r_found;
  assign xMin  = r_xmin;
  assign xMax  = r_xmax;
  assign yMin  = r_ymin;
  assign yMax  = r_ymax;

`ifdef BBOX_PIXCOUNT_EN
  logic [2*COORD_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_pix && w_dark) begin
      r_cnt <= r_cnt + (2*COORD_W)'(1);
    end
  end

  assign pix_count = r_cnt;
`endif

endmodule

// File: tb/tb_bbox_scanner.sv
// Directed plus randomized bench for bbox_scanner with a pixel-level reference model.
module tb_bbox_scanner;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int C  = 3;
  localparam int L  = 2;
  localparam int N  = W * H * C;
  localparam int ST = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        mode;
  logic [7:0]  threshold;
  logic [31:0] base_addr;
  logic        busy, done, found;
  logic [10:0] xMin, xMax, yMin, yMax;
`ifdef BBOX_PIXCOUNT_EN
  logic [21:0] pix_count;
`endif

  bbox_scanner_if #(.DATA_W(8)) bus ();

  bbox_scanner #(
    .WIDTH(W), .HEIGHT(H), .CHANNELS(C), .RD_LATENCY(L), .COORD_W(11), .DATA_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .threshold(threshold),
    .base_addr(base_addr), .mem(bus.master), .busy(busy), .done(done), .found(found),
    .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax)
`ifdef BBOX_PIXCOUNT_EN
    , .pix_count(pix_count)
`endif
  );

  // Second instance only exercises address layout with a padded row.
  logic        start2;
  logic        mode2;
  logic [7:0]  thr2;
  logic [31:0] base2;
  logic        busy2, done2, found2;
  logic [10:0] xMin2, xMax2, yMin2, yMax2;
`ifdef BBOX_PIXCOUNT_EN
  logic [21:0] pix_count2;
`endif

  bbox_scanner_if #(.DATA_W(8)) bus2 ();
  assign bus2.rddata = 8'hFF;

  bbox_scanner #(
    .WIDTH(3), .HEIGHT(2), .CHANNELS(3), .RD_LATENCY(1), .COORD_W(11), .DATA_W(8)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .threshold(thr2),
    .base_addr(base2), .mem(bus2.master), .busy(busy2), .done(done2), .found(found2),
    .xMin(xMin2), .xMax(xMax2), .yMin(yMin2), .yMax(yMax2)
`ifdef BBOX_PIXCOUNT_EN
    , .pix_count(pix_count2)
`endif
  );

  // Memory model: image bytes at base + y*ST + x*C + c, returned L cycles later.
  logic [7:0]  img [256];
  logic [7:0]  pix [W][H][C];
  logic [31:0] cur_base;
  logic [7:0]  rq  [L];
  logic [31:0] off;
  logic [31:0] addr_q[$];
  logic [31:0] addr2_q[$];

  assign off = bus.addr - cur_base;
  assign bus.rddata = rq[L-1];

  always @(posedge clk) begin
    rq[0] <= bus.rd_en ? img[off[7:0]] : 8'h00;
    for (int i = 1; i < L; i++) rq[i] <= rq[i-1];
    if (bus.rd_en) addr_q.push_back(bus.addr);
    if (bus2.rd_en) addr2_q.push_back(bus2.addr);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [7:0] v);
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        for (int c = 0; c < C; c++) pix[x][y][c] = v;
  endtask

  task automatic build_mem();
    for (int i = 0; i < 256; i++) img[i] = 8'h5A;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int c = 0; c < C; c++) img[y*ST + x*C + c] = pix[x][y][c];
  endtask

  task automatic run_scan(input logic [31:0] b, input logic m, input logic [7:0] t,
                          input int pulse_at);
    int n, bad, cnt;
    logic ef;
    int exmin, exmax, eymin, eymax;
    logic any_lo, all_lo, dk;
    int idx;
    build_mem();
    @(negedge clk);
    base_addr = b; mode = m; threshold = t; cur_base = b; start = 1'b1;
    addr_q.delete();
    @(posedge clk);
    #1;
    start = 1'b0;
    base_addr = $urandom; mode = ~m; threshold = $urandom_range(0, 255);
    chk("clr_found", found, 0);
    chk("clr_xmin", xMin, W-1);
    chk("clr_ymin", yMin, H-1);
    chk("busy_on", busy, 1);
    chk("done_off", done, 0);
    for (n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      start = (n == pulse_at);
      if (done) break;
    end
    start = 1'b0;
    chk("latency", n, N + L + 1);

    ef = 1'b0; exmin = W-1; exmax = 0; eymin = H-1; eymax = 0; cnt = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        any_lo = 1'b0; all_lo = 1'b1;
        for (int c = 0; c < C; c++) begin
          any_lo = any_lo | (pix[x][y][c] < t);
          all_lo = all_lo & (pix[x][y][c] < t);
        end
        dk = m ? all_lo : any_lo;
        if (dk) begin
          ef = 1'b1; cnt++;
          if (x < exmin) exmin = x;
          if (x > exmax) exmax = x;
          if (y < eymin) eymin = y;
          if (y > eymax) eymax = y;
        end
      end
    chk("found", found, ef);
    chk("xMin", xMin, exmin);
    chk("xMax", xMax, exmax);
    chk("yMin", yMin, eymin);
    chk("yMax", yMax, eymax);
`ifdef BBOX_PIXCOUNT_EN
    chk("pix_count", pix_count, cnt);
`endif
    chk("n_reads", addr_q.size(), N);
    bad = 0; idx = 0;
    for (int y = H-1; y >= 0; y--)
      for (int x = 0; x < W; x++)
        for (int c = 0; c < C; c++) begin
          if (idx >= addr_q.size() || addr_q[idx] !== b + y*ST + x*C + c) bad++;
          idx++;
        end
    chk("addr_seq_bad", bad, 0);
    chk("done_addr", bus.addr, b);
    chk("done_rden", bus.rd_en, 0);
  endtask

  initial begin
    int n2;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; threshold = 8'd0; base_addr = 32'd0;
    cur_base = 32'd0; start2 = 1'b0; mode2 = 1'b0; thr2 = 8'd0; base2 = 32'h100;
    set_all(8'hFF);
    build_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rden", bus.rd_en, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_found", found, 0);
    chk("rst_xMin", xMin, W-1);
    chk("rst_yMin", yMin, H-1);
    chk("rst_xMax", xMax, 0);
    chk("rst_yMax", yMax, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Padded-row addressing on the 3x2 instance.
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    for (n2 = 0; n2 < 100; n2++) begin
      @(posedge clk);
      #1;
      if (done2) break;
    end
    chk("d2_done", done2, 1);
    chk("d2_reads", addr2_q.size(), 18);
    chk("d2_row1_first", (addr2_q.size() > 0) ? addr2_q[0] : 32'hFFFF_FFFF, 32'h10C);
    chk("d2_row0_px2", (addr2_q.size() > 15) ? addr2_q[15] : 32'hFFFF_FFFF, 32'h106);
    chk("d2_found", found2, 0);
    chk("d2_xMin", xMin2, 2);
    chk("d2_yMin", yMin2, 1);
    chk("d2_busy", busy2, 0);

    // Single dark pixel at (2,1).
    set_all(8'hFF);
    pix[2][1][0] = 8'h00;
    run_scan(32'h40, 1'b0, 8'd250, 0);
    chk("A_xMin", xMin, 2);
    chk("A_xMax", xMax, 2);
    chk("A_yMin", yMin, 1);
    chk("A_yMax", yMax, 1);
    chk("A_found", found, 1);

    // No dark pixel, restarted from DONE.
    set_all(8'hFF);
    run_scan(32'h1000, 1'b0, 8'd250, 0);
    chk("B_found", found, 0);
    chk("B_xMin", xMin, 3);
    chk("B_xMax", xMax, 0);
    chk("B_yMin", yMin, 2);
    chk("B_yMax", yMax, 0);

    // ANY vs ALL, mid-scan start pulse, new threshold on restart.
    set_all(8'hFF);
    pix[1][0][0] = 8'd10;
    run_scan(32'h200, 1'b0, 8'd250, 0);
    chk("C_any_found", found, 1);
    run_scan(32'h200, 1'b1, 8'd250, 5);
    chk("C_all_found", found, 0);
    run_scan(32'h200, 1'b0, 8'd5, 12);
    chk("C_lowthr_found", found, 0);

    for (int k = 0; k < 6; k++) begin
      set_all(8'hFF);
      for (int j = 0; j < int'($urandom_range(0, 3)); j++)
        for (int c = 0; c < C; c++)
          pix[$urandom_range(0, W-1)][$urandom_range(0, H-1)][c] = 8'($urandom_range(0, 255));
      run_scan($urandom & 32'hFFFF_FF00, 1'($urandom_range(0, 1)),
               8'($urandom_range(1, 255)), int'($urandom_range(0, 30)));
    end

    // Reset during a scan.
    set_all(8'h00);
    build_mem();
    @(negedge clk);
    start = 1'b1; mode = 1'b0; threshold = 8'd200; base_addr = 32'h0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("R_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("R_done", done, 0);
    chk("R_busy", busy, 0);
    chk("R_rden", bus.rd_en, 0);
    chk("R_addr", bus.addr, 0);
    chk("R_found", found, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("R_idle_done", done, 0);
    chk("R_idle_found", found, 0);
    chk("R_idle_xMin", xMin, W-1);

    set_all(8'hFF);
    pix[3][2][1] = 8'd3;
    pix[0][0][2] = 8'd7;
    run_scan(32'h300, 1'b0, 8'd100, 0);
    chk("R_fresh_xMin", xMin, 0);
    chk("R_fresh_yMax", yMax, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bbox_scanner.md
BBOX_SCANNER -- requirements
Module: bbox_scanner

Interface
REQ-001 SHALL have parameters WIDTH (default 100): image width in pixels.
REQ-002 SHALL have HEIGHT (default 100): image height in pixels.
REQ-003 SHALL have CHANNELS (default 3, legal 1..4): bytes per pixel.
REQ-004 SHALL have RD_LATENCY (default 1, legal 1..4): cycles from addr to valid rddata.
REQ-005 SHALL have COORD_W (default 11): coordinate width.
REQ-006 SHALL have DATA_W (default 8): sample width.
REQ-007 SHALL have ports: clk  in  1  sole clock; rising edge.
REQ-008 SHALL have ports: rst_n  in  1  reset; asynchronous, active-low.
REQ-009 SHALL have start  in  1  begin scan; sampled in IDLE/DONE only.
REQ-010 SHALL have mode  in  1  0 = pixel dark if ANY channel < threshold; 1 = dark if ALL channels < threshold.
REQ-011 SHALL have threshold  in  DATA_W  darkness threshold.
REQ-012 SHALL have base_addr  in  32  image data start address.
REQ-013 SHALL have addr  out  32  read address.
REQ-014 SHALL have rd_en  out  1  address valid this cycle.
REQ-015 SHALL have rddata  in  DATA_W  sample, valid RD_LATENCY cycles after its rd_en.
REQ-016 SHALL have busy  out  1  high in SCAN/DRAIN.
REQ-017 SHALL have done  out  1  high in DONE; results valid.
REQ-018 SHALL have found  out  1  at least one dark pixel seen.
REQ-019 SHALL have xMin, xMax, yMin, yMax  out  COORD_W each  bounding box.

Function
REQ-020 SHALL implement states IDLE -> SCAN (start) -> DRAIN (last address issued) -> DONE (last sample consumed); DONE -> SCAN on start; start ignored in SCAN/DRAIN.
REQ-021 SHALL latch base_addr, mode, threshold on the accepting start edge; later changes have no effect mid-scan.
REQ-022 SHALL clear results on accepting start: xMin=WIDTH-1, yMin=HEIGHT-1, xMax=0, yMax=0, found=0.
REQ-023 SHALL issue one read per cycle in SCAN: y from HEIGHT-1 down to 0 inclusive, x from 0 to WIDTH-1, channel 0 to CHANNELS-1.
REQ-024 SHALL compute addr = base + y*STRIDE + x*CHANNELS + c, STRIDE = WIDTH*CHANNELS rounded up to a multiple of 4 (row padding).
REQ-025 SHALL carry (x, y, c, last) alongside each read through an RD_LATENCY-deep pipeline; sample paired only with its own coordinates.
REQ-026 SHALL evaluate dark/not-dark on arrival of channel CHANNELS-1, then update min/max/found on the next edge.
REQ-027 SHALL raise done exactly W*H*C + RD_LATENCY + 1 cycles after the accepting start edge; done held until next accepted start.
REQ-028 SHALL drive rd_en=0, addr=base_addr latched value, outside SCAN.
REQ-029 SHALL leave results at cleared values with found=0 when no pixel is dark.

Reset
REQ-030 SHALL on rst_n low, asynchronously, force IDLE, busy=0, done=0, rd_en=0, addr=0, results to cleared values, pipeline valid bits to 0.
REQ-031 SHALL abandon a scan on reset mid-operation; in-flight samples discarded; no result update after reset release.

Configuration
REQ-032 SHALL, with BBOX_PIXCOUNT_EN defined, add output pix_count (2*COORD_W bits): dark pixels counted, cleared on start/reset, valid with done.
REQ-033 SHALL, without BBOX_PIXCOUNT_EN, omit pix_count port and counter; all other behaviour identical.

Structure
REQ-034 SHALL place state enum, mode encoding and stride-rounding function in package bbox_pkg.
REQ-035 SHALL implement address/coordinate sequencing in sub-module bbox_addr_gen.

Verification
REQ-036 SHALL cover: W=4,H=3,C=3,LAT=2, dark (R=0) at (2,1), thr=250 -> bbox 2/2/1/1, found=1, pix_count=1, done 39 cycles after start.
REQ-037 SHALL cover: all samples 255 -> found=0, xMin=3, xMax=0, yMin=2, yMax=0.
REQ-038 SHALL cover: pixel R=10,G=255,B=255, thr=250 -> mode 0 found=1; mode 1 found=0.
REQ-039 SHALL cover: W=3,C=3,base=0x100 -> first read of row 1 at 0x10C (STRIDE 12); row 0 pixel 2 at 0x106.
REQ-040 SHALL cover: rst_n low at cycle 10 of scan -> done=0, busy=0, rd_en=0 immediately; next start yields correct fresh result.
REQ-041 SHALL cover: start pulsed mid-scan ignored; start in DONE reclears and rescans with new threshold.
